// File: rtl/laser500_sdram_arbiter_pkg.sv
// Shared types and constants for the Laser 500 SDRAM arbiter.
package laser500_sdram_arbiter_pkg;

   localparam int unsigned SDRAM_ADDR_W = 25;

   typedef logic [1:0] gnt_t;

   localparam gnt_t GNT_NONE = 2'd0;
   localparam gnt_t GNT_DIO  = 2'd1;
   localparam gnt_t GNT_VDC  = 2'd2;
   localparam gnt_t GNT_AUX  = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StDone
   } arb_state_t;

   // Only vdc/aux take part in the round-robin; dio has absolute priority.
   function automatic logic is_rr_owner(gnt_t g);
      return (g == GNT_VDC) || (g == GNT_AUX);
   endfunction

endpackage

// File: rtl/laser500_sdram_arbiter_if.sv
// Requester and SDRAM-side signals of the arbiter, bundled with requester/arbiter views.
interface laser500_sdram_arbiter_if
   import laser500_sdram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = SDRAM_ADDR_W
);
   logic              dio_req;
   logic [ADDR_W-1:0] dio_addr;
   logic [7:0]        dio_din;
   logic              dio_ack;

   logic              vdc_req;
   logic              vdc_we;
   logic [ADDR_W-1:0] vdc_addr;
   logic [7:0]        vdc_din;
   logic              vdc_ack;

   logic              aux_req;
   logic              aux_we;
   logic [ADDR_W-1:0] aux_addr;
   logic [7:0]        aux_din;
   logic              aux_ack;

   logic [7:0]        rdata;
   gnt_t              grant;

   logic [ADDR_W-1:0] sdram_addr;
   logic [7:0]        sdram_din;
   logic              sdram_we;
   logic              sdram_oe;
   logic [7:0]        sdram_dout;

   // Requesters plus the SDRAM device.
   modport master (
      output dio_req, dio_addr, dio_din,
      output vdc_req, vdc_we, vdc_addr, vdc_din,
      output aux_req, aux_we, aux_addr, aux_din,
      output sdram_dout,
      input  dio_ack, vdc_ack, aux_ack, rdata, grant,
      input  sdram_addr, sdram_din, sdram_we, sdram_oe
   );

   // The arbiter.
   modport slave (
      input  dio_req, dio_addr, dio_din,
      input  vdc_req, vdc_we, vdc_addr, vdc_din,
      input  aux_req, aux_we, aux_addr, aux_din,
      input  sdram_dout,
      output dio_ack, vdc_ack, aux_ack, rdata, grant,
      output sdram_addr, sdram_din, sdram_we, sdram_oe
   );

endinterface

// File: rtl/laser500_sdram_arbiter_pick.sv
// Winner select: dio absolute priority, vdc/aux alternate on ties via rr_last.
module laser500_sdram_arbiter_pick
   import laser500_sdram_arbiter_pkg::*;
(
   input  logic dio_req,
   input  logic vdc_req,
   input  logic aux_req,
   input  gnt_t rr_last,
   output gnt_t winner
);

   always_comb begin
      winner = GNT_NONE;
      if (dio_req) begin
         winner = GNT_DIO;
      end else if (vdc_req && aux_req) begin
         winner = (rr_last == GNT_VDC) ? GNT_AUX : GNT_VDC;
      end else if (vdc_req) begin
         winner = GNT_VDC;
      end else if (aux_req) begin
         winner = GNT_AUX;
      end
   end

endmodule

// File: rtl/laser500_sdram_arbiter.sv
// Three-way SDRAM port arbiter: one fixed-length access at a time, 1-cycle ack after each.
module laser500_sdram_arbiter
   import laser500_sdram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
   parameter int unsigned ACC_CYCLES = 3
) (
   input logic                    F14M,
   input logic                    RESET,
   laser500_sdram_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(ACC_CYCLES);
   localparam logic [CntW-1:0] CntInit = CntW'(ACC_CYCLES - 1);

   arb_state_t        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   gnt_t              owner_q, owner_d;
   gnt_t              rr_last_q, rr_last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              we_q, we_d;
   logic [7:0]        rdata_q, rdata_d;
   gnt_t              winner;

   laser500_sdram_arbiter_pick u_pick (
      .dio_req (bus.dio_req),
      .vdc_req (bus.vdc_req),
      .aux_req (bus.aux_req),
      .rr_last (rr_last_q),
      .winner  (winner)
   );

   always_ff @(posedge F14M) begin
      if (RESET) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         owner_q   <= GNT_NONE;
         rr_last_q <= GNT_AUX;
         addr_q    <= '0;
         din_q     <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      addr_d    = addr_q;
      din_d     = din_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      case (state_q)
         StIdle: begin
            if (winner != GNT_NONE) begin
               state_d = StAccess;
               owner_d = winner;
               cnt_d   = CntInit;
               case (winner)
                  GNT_DIO: begin
                     addr_d = bus.dio_addr;
                     din_d  = bus.dio_din;
                     we_d   = 1'b1;
                  end
                  GNT_VDC: begin
                     addr_d = bus.vdc_addr;
                     din_d  = bus.vdc_din;
                     we_d   = bus.vdc_we;
                  end
                  default: begin
                     addr_d = bus.aux_addr;
                     din_d  = bus.aux_din;
                     we_d   = bus.aux_we;
                  end
               endcase
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               if (!we_q) begin
                  rdata_d = bus.sdram_dout;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            if (is_rr_owner(owner_q)) begin
               rr_last_d = owner_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Strobes exist only in ACCESS, so every access starts with a fresh we/oe edge.
   always_comb begin
      bus.sdram_addr = addr_q;
      bus.sdram_din  = din_q;
      bus.sdram_we   = 1'b0;
      bus.sdram_oe   = 1'b0;
      bus.grant      = GNT_NONE;
      bus.rdata      = rdata_q;
      bus.dio_ack    = 1'b0;
      bus.vdc_ack    = 1'b0;
      bus.aux_ack    = 1'b0;
      if (state_q == StAccess) begin
         bus.sdram_we = we_q;
         bus.sdram_oe = !we_q;
         bus.grant    = owner_q;
      end
      if (state_q == StDone) begin
         bus.dio_ack = (owner_q == GNT_DIO);
         bus.vdc_ack = (owner_q == GNT_VDC);
         bus.aux_ack = (owner_q == GNT_AUX);
      end
   end

endmodule

// File: tb/tb_laser500_sdram_arbiter.sv
// Bench for laser500_sdram_arbiter: vector table, corner sequences, randomized traffic.
module tb_laser500_sdram_arbiter;
   import laser500_sdram_arbiter_pkg::*;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned ACC    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   laser500_sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   laser500_sdram_arbiter #(
      .ADDR_W     (ADDR_W),
      .ACC_CYCLES (ACC)
   ) dut (
      .F14M  (clk),
      .RESET (rst),
      .bus   (bus)
   );

   // Small SDRAM model: 16 bytes selected by the low address nibble.
   logic [7:0] mem [16];
   logic       use_mem = 1'b0;
   logic [7:0] dout_val = 8'h00;

   function automatic logic [7:0] init_val(int i);
      return 8'(i * 29 + 51);
   endfunction

   assign bus.sdram_dout = use_mem ? mem[bus.sdram_addr[3:0]] : dout_val;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (bus.sdram_we) begin
         mem[bus.sdram_addr[3:0]] <= bus.sdram_din;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // src: 0 dio, 1 vdc, 2 aux
   task automatic drive(input int src, input logic req, input logic we,
                        input logic [ADDR_W-1:0] addr, input logic [7:0] din);
      case (src)
         0: begin bus.dio_req = req; bus.dio_addr = addr; bus.dio_din = din; end
         1: begin bus.vdc_req = req; bus.vdc_we = we; bus.vdc_addr = addr; bus.vdc_din = din; end
         default: begin
            bus.aux_req = req; bus.aux_we = we; bus.aux_addr = addr; bus.aux_din = din;
         end
      endcase
   endtask

   function automatic logic [2:0] acks();
      return {bus.aux_ack, bus.vdc_ack, bus.dio_ack};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, '0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      int                src;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
      logic              use_mem;
      logic [7:0]        dout;
      int                exp_we;
      int                exp_oe;
      logic [7:0]        exp_rdata;
   } vec_t;

   vec_t vt[6];

   task automatic run_vec(input vec_t v, input int id);
      int         nwe, noe, lat;
      logic       addr_ok, din_ok;
      logic [2:0] a, a_seen;
      use_mem  = v.use_mem;
      dout_val = v.dout;
      drive(v.src, 1'b1, v.we, v.addr, v.din);
      nwe = 0; noe = 0; lat = 0; addr_ok = 1'b1; din_ok = 1'b1; a_seen = '0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         tick();
         if (bus.sdram_we) nwe++;
         if (bus.sdram_oe) noe++;
         if ((bus.sdram_we || bus.sdram_oe) && bus.sdram_addr !== v.addr) addr_ok = 1'b0;
         if (bus.sdram_we && bus.sdram_din !== v.din) din_ok = 1'b0;
         a = acks();
         if (a != 3'b000) begin
            lat = n;
            a_seen = a;
         end
      end
      drive(v.src, 1'b0, 1'b0, '0, 8'h00);
      check($sformatf("vec%0d_latency", id), lat, ACC + 1);
      check($sformatf("vec%0d_ack_src", id), a_seen, 32'(1 << v.src));
      check($sformatf("vec%0d_we_cycles", id), nwe, v.exp_we);
      check($sformatf("vec%0d_oe_cycles", id), noe, v.exp_oe);
      check($sformatf("vec%0d_addr", id), addr_ok, 1);
      check($sformatf("vec%0d_din", id), din_ok, 1);
      check($sformatf("vec%0d_rdata", id), bus.rdata, v.exp_rdata);
      tick();
      tick();
   endtask

   // Reference choice from the requests visible in the deciding IDLE cycle.
   function automatic int ref_pick(logic [2:0] reqs, int last_rr);
      if (reqs[0]) return 0;
      if (reqs[1] && reqs[2]) return (last_rr == 1) ? 2 : 1;
      if (reqs[1]) return 1;
      if (reqs[2]) return 2;
      return -1;
   endfunction

   logic [7:0] ref_mem [16];

   initial begin
      int         k, first_gnt, din_first, flag, lat, noe, acked;
      int         order[4];
      int         when[4];
      logic [2:0] a;

      for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, '0, 8'h00);
      do_reset();

      check("reset_grant", bus.grant, GNT_NONE);
      check("reset_strobes", {bus.sdram_we, bus.sdram_oe}, 0);
      check("reset_acks", acks(), 0);
      check("reset_rdata", bus.rdata, 0);
      check("reset_addr", bus.sdram_addr, 0);

      vt[0] = '{1, 1'b0, 25'h0000000, 8'h00, 1'b0, 8'hF3, 0, 3, 8'hF3};
      vt[1] = '{0, 1'b1, 25'h01C3800, 8'h41, 1'b1, 8'h00, 3, 0, 8'hF3};
      vt[2] = '{2, 1'b1, 25'h0001234, 8'h42, 1'b1, 8'h00, 3, 0, 8'hF3};
      vt[3] = '{2, 1'b0, 25'h0001234, 8'h00, 1'b1, 8'h00, 0, 3, 8'h42};
      vt[4] = '{1, 1'b1, 25'h1FFFFFF, 8'h5A, 1'b1, 8'h00, 3, 0, 8'h42};
      vt[5] = '{1, 1'b0, 25'h1FFFFFF, 8'h00, 1'b1, 8'h00, 0, 3, 8'h5A};
      for (int i = 0; i < 6; i++) run_vec(vt[i], i);

      // vdc and aux both held: strict alternation, 5 cycles apart
      do_reset();
      use_mem = 1'b1;
      drive(1, 1'b1, 1'b0, 25'h5, 8'h00);
      drive(2, 1'b1, 1'b0, 25'h6, 8'h00);
      k = 0;
      for (int i = 0; i < 4; i++) begin order[i] = 0; when[i] = 0; end
      for (int n = 0; n < 60 && k < 4; n++) begin
         tick();
         a = acks();
         if (a != 3'b000) begin
            order[k] = a;
            when[k]  = n;
            k++;
         end
      end
      drive(1, 1'b0, 1'b0, '0, 8'h00);
      drive(2, 1'b0, 1'b0, '0, 8'h00);
      check("alt_count", k, 4);
      for (int i = 0; i < 4; i++) check($sformatf("alt_order%0d", i), order[i], (i % 2) ? 4 : 2);
      for (int i = 1; i < 4; i++) check($sformatf("alt_space%0d", i), when[i] - when[i-1], 5);

      // dio beats a pending vdc; vdc follows
      do_reset();
      drive(0, 1'b1, 1'b1, 25'h01C3800, 8'h41);
      drive(1, 1'b1, 1'b0, 25'h10, 8'h00);
      k = 0; first_gnt = 0; din_first = -1;
      for (int i = 0; i < 4; i++) order[i] = 0;
      for (int n = 0; n < 40 && k < 2; n++) begin
         tick();
         if (first_gnt == 0 && bus.grant != GNT_NONE) first_gnt = int'(bus.grant);
         if (din_first < 0 && bus.sdram_we) din_first = int'(bus.sdram_din);
         a = acks();
         if (a != 3'b000) begin
            order[k] = a;
            k++;
            if (a[0]) drive(0, 1'b0, 1'b0, '0, 8'h00);
            if (a[1]) drive(1, 1'b0, 1'b0, '0, 8'h00);
         end
      end
      drive(0, 1'b0, 1'b0, '0, 8'h00);
      drive(1, 1'b0, 1'b0, '0, 8'h00);
      check("dio_first_grant", first_gnt, GNT_DIO);
      check("dio_din", din_first, 32'h41);
      check("dio_ack_first", order[0], 1);
      check("vdc_ack_second", order[1], 2);

      // RESET in the 2nd ACCESS cycle, then the held request is re-served
      do_reset();
      use_mem = 1'b0;
      dout_val = 8'h77;
      drive(1, 1'b1, 1'b0, 25'h20, 8'h00);
      tick();
      tick();
      check("rst_mid_pre_grant", bus.grant, GNT_VDC);
      rst = 1'b1;
      tick();
      check("rst_mid_grant", bus.grant, GNT_NONE);
      check("rst_mid_strobes", {bus.sdram_we, bus.sdram_oe}, 0);
      check("rst_mid_acks", acks(), 0);
      rst = 1'b0;
      lat = 0; noe = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         tick();
         if (bus.sdram_oe) noe++;
         if (acks() != 3'b000) lat = n;
      end
      drive(1, 1'b0, 1'b0, '0, 8'h00);
      check("rst_reserve_latency", lat, ACC + 1);
      check("rst_reserve_oe", noe, ACC);
      check("rst_reserve_rdata", bus.rdata, 8'h77);
      tick();

      // vdc pulsed for one cycle while dio is busy: never issued
      do_reset();
      drive(0, 1'b1, 1'b1, 25'h3, 8'h99);
      tick();
      drive(1, 1'b1, 1'b0, 25'h7, 8'h00);
      tick();
      drive(1, 1'b0, 1'b0, '0, 8'h00);
      acked = 0;
      for (int n = 0; n < 20 && acked == 0; n++) begin
         tick();
         if (bus.dio_ack) acked = 1;
      end
      drive(0, 1'b0, 1'b0, '0, 8'h00);
      check("pulse_dio_acked", acked, 1);
      flag = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bus.grant != GNT_NONE || acks() != 3'b000) flag = 1;
      end
      check("pulse_vdc_dropped", flag, 0);

      // Randomized traffic against a reference model
      begin
         logic              pend[3];
         logic              p_we[3];
         logic [ADDR_W-1:0] p_addr[3];
         logic [7:0]        p_din[3];
         logic [2:0]        prev_req;
         logic [7:0]        last_rdata;
         int                owner, strobes, bad, rr_m, exp_owner, idx;
         gnt_t              g, prev_g;

         do_reset();
         use_mem = 1'b1;
         for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
         for (int s = 0; s < 3; s++) begin
            pend[s] = 1'b0; p_we[s] = 1'b0; p_addr[s] = '0; p_din[s] = '0;
         end
         prev_req = '0; last_rdata = 8'h00; owner = -1; strobes = 0; bad = 0;
         rr_m = 2; prev_g = GNT_NONE;

         for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc >= 3000 && !pend[0] && !pend[1] && !pend[2]) break;
            tick();
            g = bus.grant;
            if (g != GNT_NONE && prev_g == GNT_NONE) begin
               exp_owner = ref_pick(prev_req, rr_m);
               check("rnd_grant", g, 32'(exp_owner + 1));
               owner = int'(g) - 1;
               strobes = 0;
               bad = 0;
            end
            if (bus.sdram_we || bus.sdram_oe) begin
               strobes++;
               if (owner < 0) bad = 1;
               else if (bus.sdram_addr !== p_addr[owner] || bus.sdram_we !== p_we[owner] ||
                        (p_we[owner] && bus.sdram_din !== p_din[owner])) bad = 1;
            end
            a = acks();
            if (a != 3'b000) begin
               if (owner < 0) begin
                  check("rnd_ack_unowned", a, 0);
               end else begin
                  check("rnd_ack_owner", a, 32'(1 << owner));
                  check("rnd_strobes", strobes, ACC);
                  check("rnd_bus", bad, 0);
                  idx = int'(p_addr[owner][3:0]);
                  if (p_we[owner]) begin
                     ref_mem[idx] = p_din[owner];
                     check("rnd_rdata_hold", bus.rdata, last_rdata);
                  end else begin
                     check("rnd_rdata", bus.rdata, ref_mem[idx]);
                  end
                  last_rdata = bus.rdata;
                  if (owner != 0) rr_m = owner;
                  pend[owner] = 1'b0;
                  drive(owner, 1'b0, 1'b0, '0, 8'h00);
                  owner = -1;
               end
            end
            prev_g = g;
            for (int s = 0; s < 3; s++) begin
               if (!pend[s] && cyc < 3000 && ($urandom % 4) == 0) begin
                  idx       = int'($urandom_range(0, 15));
                  pend[s]   = 1'b1;
                  p_we[s]   = (s == 0) ? 1'b1 : 1'($urandom % 2);
                  p_addr[s] = (ADDR_W'(idx) << 21) | ADDR_W'(idx);
                  p_din[s]  = 8'($urandom);
                  drive(s, 1'b1, p_we[s], p_addr[s], p_din[s]);
               end
               prev_req[s] = pend[s];
            end
         end
         check("rnd_drained", {pend[0], pend[1], pend[2]}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
